// File: rtl/pipeline_if_prefetch_if.sv
// Signal bundle between the fetch stage (master) and its environment:
// ID redirect inputs, the instruction-memory port and the IF->ID output.
interface pipeline_if_prefetch_if;
  logic [2:0]  pc_src;
  logic        alu_out0;
  logic [31:0] con_ba;
  logic [31:0] id_busa;
  logic [25:0] jt;
  logic [31:0] id_pc4;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    input  pc_src, alu_out0, con_ba, id_busa, jt, id_pc4,
    input  imem_gnt, imem_rvalid, imem_rdata, stall,
    output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4
  );

  modport slave (
    output pc_src, alu_out0, con_ba, id_busa, jt, id_pc4,
    output imem_gnt, imem_rvalid, imem_rdata, stall,
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4
  );
endinterface

// File: rtl/pipeline_if_prefetch.sv
// Fetch stage: up to DEPTH requests in flight or queued, in-order imem responses, flush + discard on ID redirect.
// Grant-to-if_valid is 2 cycles; define PIPELINE_IF_BYPASS_EN to show a response the same cycle when the queue is empty.
module pipeline_if_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_if_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Back-to-back redirects can stack stale responses beyond DEPTH, so one spare bit.
  localparam int unsigned DW = PW + 2;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [PW-1:0] af_rd_q, af_rd_d, af_wr_q, af_wr_d;

  logic [31:0] q_pc_mem   [DEPTH];
  logic [31:0] q_inst_mem [DEPTH];
  logic [31:0] af_mem     [DEPTH];

  logic        redirect;
  logic [31:0] target;

  always_comb begin
    redirect = 1'b0;
    target   = fetch_pc_q;
    case (bus.pc_src)
      3'd1: begin
        redirect = ~bus.alu_out0;
        target   = bus.con_ba;
      end
      3'd2: begin
        redirect = 1'b1;
        target   = {bus.id_pc4[31:28], bus.jt, 2'b00};
      end
      3'd3: begin
        redirect = 1'b1;
        target   = bus.id_busa;
      end
      3'd4: begin
        redirect = 1'b1;
        target   = IRQ_VEC;
      end
      3'd5: begin
        redirect = 1'b1;
        target   = EXC_VEC;
      end
      default: ;
    endcase
  end

  logic        unused_pc4_low;
  assign unused_pc4_low = ^bus.id_pc4[27:0];

  logic [CW:0] used;
  logic        credit, req, gnt_acc, resp, stale, bypass;
  logic        valid, pop, pop_q, push;
  logic [31:0] head_pc, head_inst;

  always_comb begin
    used    = {1'b0, occ_q} + {1'b0, inflight_q};
    credit  = used < DEPTH_W;
    req     = ~reset & ~redirect & credit;
    gnt_acc = req & bus.imem_gnt;
    stale   = bus.imem_rvalid & (discard_q != '0);
    resp    = bus.imem_rvalid & (discard_q == '0);
`ifdef PIPELINE_IF_BYPASS_EN
    bypass  = ~reset & ~redirect & resp & (occ_q == '0);
`else
    bypass  = 1'b0;
`endif
    valid     = bypass | (occ_q != '0);
    head_pc   = bypass ? af_mem[af_rd_q] : q_pc_mem[q_rd_q];
    head_inst = bypass ? bus.imem_rdata : q_inst_mem[q_rd_q];
    pop       = valid & ~bus.stall & ~redirect;
    pop_q     = pop & (occ_q != '0);
    // A bypassed response that ID takes immediately never touches the queue.
    push      = resp & ~redirect & ~(bypass & ~bus.stall);
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = valid;
  assign bus.if_inst   = valid ? head_inst : '0;
  assign bus.if_pc     = valid ? head_pc : '0;
  assign bus.if_pc4    = valid ? head_pc + 32'd4 : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    af_rd_d    = af_rd_q;
    af_wr_d    = af_wr_q;
    if (redirect) begin
      // Everything outstanding becomes stale; a response landing now is already accounted for.
      fetch_pc_d = target;
      occ_d      = '0;
      q_rd_d     = q_wr_q;
      inflight_d = '0;
      discard_d  = discard_q + DW'(inflight_q) - DW'(bus.imem_rvalid);
      af_rd_d    = af_wr_q;
    end else begin
      if (gnt_acc) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        af_wr_d    = af_wr_q + 1'b1;
      end
      if (resp) begin
        af_rd_d = af_rd_q + 1'b1;
      end
      if (push) begin
        q_wr_d = q_wr_q + 1'b1;
      end
      if (pop_q) begin
        q_rd_d = q_rd_q + 1'b1;
      end
      occ_d      = occ_q + CW'(push) - CW'(pop_q);
      inflight_d = inflight_q + CW'(gnt_acc) - CW'(resp);
      discard_d  = discard_q - DW'(stale);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_VEC;
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      af_rd_q    <= '0;
      af_wr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      af_rd_q    <= af_rd_d;
      af_wr_q    <= af_wr_d;
    end
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_mem[q_wr_q]   <= af_mem[af_rd_q];
      q_inst_mem[q_wr_q] <= bus.imem_rdata;
    end
    if (gnt_acc) begin
      af_mem[af_wr_q] <= fetch_pc_q;
    end
  end
endmodule

// File: tb/tb_pipeline_if_prefetch.sv
// Bench for pipeline_if_prefetch: in-order variable-latency memory model plus an
// expected-stream model (next PC ID should see, next address imem should be asked for).
`timescale 1ns/1ps
module tb_pipeline_if_prefetch;
  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;
`ifdef PIPELINE_IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_if_prefetch_if bus();
  pipeline_if_prefetch #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } pend_t;
  pend_t pend[$];

  int unsigned cyc, n_vec, n_err, gnt_pct, lat_min, lat_max, n_cons, n_gnt, c0;
  logic [31:0] m_fetch, exp_pc, last_pc;
  logic        s_req, s_valid, consumed;
  logic [31:0] s_addr, s_inst, s_pc, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    bus.imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  endtask

  // One clock: sample mid-cycle, check against the model, advance model and memory.
  task automatic step();
    logic        rd;
    logic [31:0] tgt;
    @(negedge clk);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.if_valid;
    s_inst  = bus.if_inst;
    s_pc    = bus.if_pc;
    s_pc4   = bus.if_pc4;
    rd  = 1'b1;
    tgt = '0;
    case (bus.pc_src)
      3'd1: begin rd = !bus.alu_out0; tgt = bus.con_ba; end
      3'd2: tgt = {bus.id_pc4[31:28], bus.jt, 2'b00};
      3'd3: tgt = bus.id_busa;
      3'd4: tgt = IRQ_V;
      3'd5: tgt = EXC_V;
      default: rd = 1'b0;
    endcase
    consumed = 1'b0;
    if (rd) begin
      chk("req_during_redirect", s_req, 0);
      exp_pc  = tgt;
      m_fetch = tgt;
    end else begin
      if (s_req) chk("imem_addr", s_addr, m_fetch);
      if (s_valid && !bus.stall) begin
        consumed = 1'b1;
        n_cons++;
        last_pc = s_pc;
        chk("if_pc", s_pc, exp_pc);
        chk("if_inst", s_inst, mem_word(exp_pc));
        chk("if_pc4", s_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (s_req && bus.imem_gnt) begin
        pend.push_back('{addr: s_addr, ready: cyc + $urandom_range(lat_max, lat_min)});
        m_fetch = m_fetch + 32'd4;
        n_gnt++;
      end
    end
    if (bus.imem_rvalid && pend.size() > 0) pend.delete(0);
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset(input int unsigned gp, input int unsigned lmin, input int unsigned lmax);
    reset = 1'b1;
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_inst", bus.if_inst, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_if_pc4", bus.if_pc4, 0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.stall       = 1'b0;
    bus.pc_src      = 3'd0;
    pend.delete();
    gnt_pct = gp;
    lat_min = lmin;
    lat_max = lmax;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    cyc     = 0;
    m_fetch = RST_V;
    exp_pc  = RST_V;
    drive_mem();
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_cons = 0; n_gnt = 0; cyc = 0;
    bus.pc_src = 3'd0; bus.alu_out0 = 1'b1; bus.con_ba = '0; bus.id_busa = '0;
    bus.jt = '0; bus.id_pc4 = '0; bus.stall = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

    // Back-to-back fetch, 1-cycle memory: latency and 1/cycle throughput.
    do_reset(100, 1, 1);
    step();
    chk("c0_req", s_req, 1);
    chk("c0_addr", s_addr, RST_V);
    chk("c0_valid", s_valid, 0);
    step();
    chk("c1_valid", s_valid, BYP);
    step();
    chk("c2_valid", s_valid, 1);
    c0 = n_cons;
    repeat (20) step();
    chk("throughput_20", n_cons - c0, 20);

    // Stall from reset: credit limits grants to DEPTH, head survives.
    do_reset(100, 1, 1);
    bus.stall = 1'b1;
    n_gnt = 0;
    repeat (10) step();
    chk("stall_grants", n_gnt, 4);
    chk("stall_req_low", s_req, 0);
    chk("stall_valid", s_valid, 1);
    bus.stall = 1'b0;
    c0 = n_cons;
    for (int i = 0; i < 10 && n_cons == c0; i++) step();
    chk("stall_release_pop", n_cons - c0, 1);
    chk("stall_release_head", last_pc, RST_V);
    repeat (12) step();

    // Jump with three requests in flight.
    do_reset(100, 6, 6);
    repeat (3) step();
    chk("jump_inflight", pend.size(), 3);
    bus.pc_src = 3'd2; bus.jt = 26'h000_0040; bus.id_pc4 = 32'h0000_0010;
    step();
    bus.pc_src = 3'd0;
    lat_min = 1; lat_max = 1;
    step();
    chk("jump_req", s_req, 1);
    chk("jump_addr", s_addr, 32'h0000_0100);
    c0 = n_cons;
    for (int i = 0; i < 40 && n_cons == c0; i++) step();
    chk("jump_first_pc", last_pc, 32'h0000_0100);
    repeat (5) step();

    // Branch not taken, then taken.
    bus.pc_src = 3'd1; bus.alu_out0 = 1'b1; bus.con_ba = 32'h0000_0200;
    step();
    chk("bnt_req", s_req, 1);
    bus.alu_out0 = 1'b0;
    step();
    bus.pc_src = 3'd0;
    step();
    chk("bt_req", s_req, 1);
    chk("bt_addr", s_addr, 32'h0000_0200);
    repeat (5) step();

    // IRQ in the same cycle as a response and a pop.
    bus.pc_src = 3'd4;
    step();
    chk("irq_cycle_valid", s_valid, 1);
    bus.pc_src = 3'd0;
    step();
    chk("irq_queue_empty", s_valid, 0);
    chk("irq_addr", s_addr, IRQ_V);
    c0 = n_cons;
    for (int i = 0; i < 20 && n_cons == c0; i++) step();
    chk("irq_first_pc", last_pc, IRQ_V);

    // Asynchronous reset with a partly full queue.
    do_reset(100, 1, 1);
    bus.stall = 1'b1;
    repeat (4) step();
    chk("pre_reset_valid", s_valid, 1);
    do_reset(100, 1, 1);
    step();
    chk("post_reset_req", s_req, 1);
    chk("post_reset_addr", s_addr, RST_V);

    // Random traffic: grants, latency, stalls and redirects.
    gnt_pct = 75; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      bus.stall    = ($urandom_range(3, 0) == 0);
      bus.pc_src   = ($urandom_range(15, 0) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
      bus.alu_out0 = 1'($urandom_range(1, 0));
      bus.con_ba   = $urandom & 32'hFFFF_FFFC;
      bus.id_busa  = $urandom & 32'hFFFF_FFFC;
      bus.jt       = 26'($urandom);
      bus.id_pc4   = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
